// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the serial two's-complement sequencer.
package serial_comp_pkg;

  localparam int unsigned COMP_WIDTH = 4;

  localparam logic [COMP_WIDTH-1:0] MIN_NEG = {1'b1, {(COMP_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    CAPT  = 3'd3,
    OUT   = 3'd4
  } state_t;

endpackage

// File: rtl/serial_comp_ctrl.sv
// Sequencer for the serial complementer: accepts a word, drives set/load for one
// cycle, counts WIDTH shift cycles, captures the result and offers it downstream.
module serial_comp_ctrl
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = COMP_WIDTH,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             comp_set,
  output logic [WIDTH-1:0] comp_load_sig,
  input  logic [WIDTH-1:0] comp_out_sig,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] cnt;
  logic             ready_dec;
  logic             valid_dec;
  logic             set_dec;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      data_q   <= '0;
      out_data <= '0;
      out_ovf  <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) data_q <= in_data;
        end
        LOAD:  cnt <= '0;
        SHIFT: cnt <= cnt + CNT_W'(1);
        CAPT: begin
          out_data <= comp_out_sig;
          out_ovf  <= (data_q == MIN_NEG);
          out_zero <= (data_q == '0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    ready_dec = 1'b0;
    valid_dec = 1'b0;
    set_dec   = 1'b0;
    case (state)
      IDLE: begin
        ready_dec = 1'b1;
        if (in_valid) state_nxt = LOAD;
      end
      LOAD: begin
        set_dec   = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        if (cnt == LAST_SHIFT) state_nxt = CAPT;
      end
      CAPT: state_nxt = OUT;
      OUT: begin
        valid_dec = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and set outputs are forced low while reset is asserted, even
  // before the reset edge has returned the state register to IDLE.
  assign in_ready      = rst_n & ready_dec;
  assign out_valid     = rst_n & valid_dec;
  assign comp_set      = rst_n & set_dec;
  assign comp_load_sig = data_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_serial_comp_ctrl.sv
// Bench for serial_comp_ctrl with a behavioural serial complementer peer and
// an arithmetic reference model for the expected results.
module tb_serial_comp_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       comp_set;
  logic [3:0] comp_load_sig;
  logic [3:0] comp_out_sig;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_ovf;
  logic       out_zero;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [3:0] got[$];
  int         acc[$];

  serial_comp_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .comp_set     (comp_set),
    .comp_load_sig(comp_load_sig),
    .comp_out_sig (comp_out_sig),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_ovf      (out_ovf),
    .out_zero     (out_zero),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Serial complementer peer: loads ~word with carry 1, then adds the carry
  // into the LSB while rotating right, one bit per clock.
  logic [3:0] sr = '0;
  logic       cy = 1'b0;
  always @(posedge clk) begin
    if (comp_set) begin
      sr <= ~comp_load_sig;
      cy <= 1'b1;
    end else begin
      sr <= {sr[0] ^ cy, sr[3:1]};
      cy <= sr[0] & cy;
    end
  end
  assign comp_out_sig = sr;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) got.push_back(out_data);
    if (rst_n && in_valid && in_ready) acc.push_back(cyc);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ref_neg(input logic [3:0] d);
    int v;
    v = (16 - int'(d)) % 16;
    return v[3:0];
  endfunction

  task automatic run_word(input logic [3:0] d, input int hold);
    int         n;
    int         lat;
    int         sets;
    logic [3:0] ed;
    logic       eo;
    logic       ez;
    ed = ref_neg(d);
    eo = (d == 4'd8);
    ez = (d == 4'd0);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    check("accept_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    lat  = 0;
    sets = 0;
    while (!out_valid && lat < 30) begin
      sets += int'(comp_set);
      step();
      lat++;
    end
    check("latency", lat, 6);
    check("set_cycles", sets, 1);
    for (int i = 0; i < hold; i++) begin
      check("bp_in_ready", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_data", out_data, ed);
      check("bp_ovf", out_ovf, eo);
      check("bp_zero", out_zero, ez);
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 4'($urandom);
      step();
    end
    in_valid = 1'b0;
    check("out_valid", out_valid, 1);
    check("out_data", out_data, ed);
    check("out_ovf", out_ovf, eo);
    check("out_zero", out_zero, ez);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 4'hF;
    out_ready = 1'b0;
    repeat (3) step();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_set", comp_set, 0);
    check("rst_busy", busy, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_zero", out_zero, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    run_word(4'b0101, 0);
    run_word(4'b0000, 0);
    run_word(4'b0001, 0);
    run_word(4'b1000, 0);
    run_word(4'b0111, 10);

    // Reset while shifting with the counter at 2.
    in_data  = 4'hA;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_set", comp_set, 0);
    check("mid_rst_in_ready", in_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_post_busy", busy, 0);
    check("mid_post_valid", out_valid, 0);
    check("mid_post_in_ready", in_ready, 1);
    check("mid_post_data", out_data, 0);
    run_word(4'b0011, 0);

    // Back-to-back with in_valid held and out_ready tied high.
    got.delete();
    acc.delete();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 4'b0110;
    n = 0;
    while (acc.size() < 1 && n < 40) begin
      step();
      n++;
    end
    in_data = 4'b1111;
    while (acc.size() < 2 && n < 40) begin
      step();
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (got.size() < 2 && n < 40) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    check("b2b_accepts", acc.size(), 2);
    check("b2b_results", got.size(), 2);
    if (acc.size() >= 2) check("b2b_spacing", acc[1] - acc[0], 8);
    if (got.size() >= 2) begin
      check("b2b_first", got[0], ref_neg(4'b0110));
      check("b2b_second", got[1], ref_neg(4'b1111));
    end
    step();

    for (int k = 0; k < 20; k++) begin
      run_word(4'($urandom_range(0, 15)), $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_comp_ctrl.md
Name: serial_comp_ctrl

Overview:
Upstream sequencer for the 4-bit serial two's-complement datapath (shift register plus serial half-adder unit). Accepts parallel words over a valid/ready handshake and drives that datapath's set/load_sig pins. Counts the serial shift cycles, captures the complemented word from its out_sig, and presents it downstream over a second valid/ready handshake with status flags. Sits between the producing logic and the complementer instance; both are peers instantiated in the parent.

Parameters:
WIDTH, 4, word width and number of serial shift cycles; must match the complementer (fixed at 4 today).
CNT_W, 3, counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  in  1  rising-edge clock, shared with the complementer.
rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  in  1  upstream word valid.
in_ready  out  1  controller can accept a word.
in_data  in  WIDTH  word to complement.
comp_set  out  1  to complementer set: load the register and preset carry to 1.
comp_load_sig  out  WIDTH  to complementer load_sig.
comp_out_sig  in  WIDTH  from complementer out_sig.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  two's complement of the accepted word, modulo 2**WIDTH.
out_ovf  out  1  input was the most-negative value (1 followed by zeros); result equals the input.
out_zero  out  1  input was zero.
busy  out  1  state is not IDLE.

Behaviour:
- States: IDLE, LOAD, SHIFT, CAPT, OUT. The encoding is an enum in the package.
- Reset (rst_n=0 at an edge): state goes to IDLE, counter to 0, and data_q, out_data, out_ovf and out_zero to 0.
- While rst_n=0: in_ready=0, out_valid=0, comp_set=0. Reset overrides every other event, including a reset mid-SHIFT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: data_q<=in_data, go to LOAD.
- LOAD (1 cycle):
  - comp_set=1, comp_load_sig=data_q.
  - Counter<=0, go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - comp_set=0, counter increments each cycle.
  - When counter==WIDTH-1, go to CAPT.
- CAPT (1 cycle):
  - out_data<=comp_out_sig.
  - out_ovf<=(data_q=={1'b1,{WIDTH-1{1'b0}}}).
  - out_zero<=(data_q==0).
  - Go to OUT.
- OUT:
  - out_valid=1. out_data and the flags stay stable until the handshake completes.
  - On out_ready: go to IDLE.
  - If out_ready stays low, remain in OUT indefinitely. No new word is accepted (in_ready=0).
- comp_load_sig is driven with data_q in every state. comp_set is 1 only in LOAD.
- The complementer free-runs outside LOAD/SHIFT. This is harmless because every operation starts with a LOAD.
- Latency: acceptance edge E, then out_valid=1 in the cycle after edge E+WIDTH+2 (E+6 for WIDTH=4). Throughput is one word per WIDTH+4 cycles with out_ready tied high.
- in_ready is a combinational decode of state (gated by rst_n). out_valid is a decode of state==OUT.
- No IDLE-to-OUT bypass. The out handshake and the next in handshake never complete in the same cycle.
- Counter wrap is unreachable. An illegal state encoding returns to IDLE on the next edge.

Decomposition:
- Package serial_comp_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, CAPT, OUT);
  - COMP_WIDTH=4;
  - the MIN_NEG constant (1 followed by zeros), used for the ovf compare.
- No sub-module is needed: a single FSM-plus-counter block.
- The complementer stays a separate peer instance, wired in the parent via comp_set, comp_load_sig and comp_out_sig.

Test Plan:
- Reset, then in_data=4'b0101, out_ready=1 -> out_data=4'b1011, ovf=0, zero=0. out_valid rises exactly 6 cycles after the acceptance edge; comp_set high for exactly 1 cycle.
- in_data=4'b0000 -> out_data=4'b0000, out_zero=1, out_ovf=0. in_data=4'b0001 -> out_data=4'b1111.
- in_data=4'b1000 -> out_data=4'b1000, out_ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data and flags stable, in_ready=0 throughout, in_valid pulses ignored. Release -> IDLE next cycle, in_ready=1.
- Reset mid-SHIFT (rst_n=0 for 1 edge at counter=2) -> next cycle state IDLE, out_valid=0, busy=0. A following word 4'b0011 gives 4'b1101.
- Back-to-back: in_valid held high with 4'b0110 then 4'b1111, out_ready=1 -> outputs 4'b1010 then 4'b0001, accepts spaced 8 cycles apart.
